// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes for one 128x128 frame.
//
// The block accumulates the codes written by the LBP stage. Once `finish`
// rises, it keeps accepting writes for a short drain window. It then streams
// all 256 bin counts out over a valid/ready handshake, clearing each bin as
// it is read, so the next frame starts from an empty histogram.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-low reset
//   lbp_valid   in   one pixel write this cycle
//   lbp_addr    in   {row[6:0], col[6:0]} of the pixel
//   lbp_data    in   LBP code, used as the bin index
//   finish      in   level, high once the last pixel of the frame is issued
//   hist_ready  in   consumer accepts the presented bin
//   hist_valid  out  hist_bin / hist_count are valid
//   hist_bin    out  bin index being presented
//   hist_count  out  count of hist_bin (saturating)
//   hist_done   out  one-cycle pulse after bin 255 transfers
//   overrun     out  sticky: a write arrived while reading out or done
module lbp_hist #(
  parameter int CNT_W       = 15,
  parameter bit SKIP_BORDER = 1'b1,
  parameter int DRAIN_CYC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  input  logic             hist_ready,
  output logic             hist_valid,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done,
  output logic             overrun
);

  localparam int               DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_READ,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bins_q [256];
  logic [CNT_W-1:0] bins_d [256];
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             hist_valid_q, hist_valid_d;
  logic [7:0]       hist_bin_q, hist_bin_d;
  logic [CNT_W-1:0] hist_count_q, hist_count_d;
  logic             hist_done_q, hist_done_d;
  logic             overrun_q, overrun_d;

  logic [6:0] row, col;
  logic       on_border;
  logic       accept_wr;
  logic       xfer;

  assign row = lbp_addr[13:7];
  assign col = lbp_addr[6:0];

  always_comb begin
    on_border = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
    accept_wr = lbp_valid && ((state_q == ST_ACCUM) || (state_q == ST_DRAIN)) &&
                !(SKIP_BORDER && on_border);
    xfer      = hist_valid_q && hist_ready;
  end

  // hist_bin_q doubles as the read pointer. The increment is computed into
  // bins_d before the state logic so that a write landing on the last drain
  // cycle is already reflected in the first presented count.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_done_d  = 1'b0;
    overrun_d    = overrun_q;
    for (int i = 0; i < 256; i++) begin
      bins_d[i] = bins_q[i];
    end

    if (accept_wr && (bins_q[lbp_data] != CNT_MAX)) begin
      bins_d[lbp_data] = bins_q[lbp_data] + CNT_W'(1);
    end

    if (lbp_valid && ((state_q == ST_READ) || (state_q == ST_DONE))) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_ACCUM: begin
        if (finish) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d      = ST_READ;
          hist_valid_d = 1'b1;
          hist_bin_d   = 8'd0;
          hist_count_d = bins_d[0];
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      ST_READ: begin
        if (xfer) begin
          bins_d[hist_bin_q] = '0;
          if (hist_bin_q == 8'd255) begin
            state_d      = ST_DONE;
            hist_valid_d = 1'b0;
            hist_done_d  = 1'b1;
            hist_bin_d   = 8'd0;
            hist_count_d = '0;
          end else begin
            hist_bin_d   = hist_bin_q + 8'd1;
            hist_count_d = bins_q[hist_bin_q + 8'd1];
          end
        end
      end
      ST_DONE: begin
        if (!finish) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACCUM;
      drain_cnt_q  <= '0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= 8'd0;
      hist_count_q <= '0;
      hist_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_done_q  <= hist_done_d;
      overrun_q    <= overrun_d;
      bins_q       <= bins_d;
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = hist_count_q;
  assign hist_done  = hist_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: self-checking bench for lbp_hist.
//
// Three instances share every input: default parameters, border pixels
// counted (SKIP_BORDER=0), and a 4-bit counter. A histogram model per
// instance predicts every count read out, and a table of fixed expected
// counts pins down the known frames.
module tb_lbp_hist;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbpValid;
  logic [13:0] lbpAddr;
  logic [7:0]  lbpData;
  logic        finish;
  logic        histReady;

  logic        hv [NDUT];
  logic [7:0]  hb [NDUT];
  logic        hd [NDUT];
  logic        ov [NDUT];
  logic [14:0] hcDef;
  logic [14:0] hcNb;
  logic [3:0]  hcSat;

  int checks = 0;
  int errors = 0;

  // Reference histograms, the counts captured at each transfer, and the
  // per-instance parameters the model needs.
  int refHist  [NDUT][256];
  int captured [NDUT][256];
  int cntMax   [NDUT] = '{32767, 32767, 15};
  bit skipBord [NDUT] = '{1'b1, 1'b0, 1'b1};
  bit expOverrun;

  typedef struct {
    int frame;
    int dut;
    int bin;
    int expCount;
  } vec_t;

  vec_t vecs [13];

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  lbp_hist dutDef (
    .clk(clk), .reset(reset), .lbp_valid(lbpValid), .lbp_addr(lbpAddr),
    .lbp_data(lbpData), .finish(finish), .hist_ready(histReady),
    .hist_valid(hv[0]), .hist_bin(hb[0]), .hist_count(hcDef),
    .hist_done(hd[0]), .overrun(ov[0])
  );

  lbp_hist #(.SKIP_BORDER(1'b0)) dutNb (
    .clk(clk), .reset(reset), .lbp_valid(lbpValid), .lbp_addr(lbpAddr),
    .lbp_data(lbpData), .finish(finish), .hist_ready(histReady),
    .hist_valid(hv[1]), .hist_bin(hb[1]), .hist_count(hcNb),
    .hist_done(hd[1]), .overrun(ov[1])
  );

  lbp_hist #(.CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .lbp_valid(lbpValid), .lbp_addr(lbpAddr),
    .lbp_data(lbpData), .finish(finish), .hist_ready(histReady),
    .hist_valid(hv[2]), .hist_bin(hb[2]), .hist_count(hcSat),
    .hist_done(hd[2]), .overrun(ov[2])
  );

  // Returns the presented count of one instance as a plain integer.
  function automatic int countOf(int k);
    case (k)
      0:       return int'(hcDef);
      1:       return int'(hcNb);
      default: return int'(hcSat);
    endcase
  endfunction

  // Picks a random pixel address that is never on the frame border.
  function automatic logic [13:0] interiorAddr();
    logic [6:0] r;
    logic [6:0] c;
    r = 7'($urandom_range(1, 126));
    c = 7'($urandom_range(1, 126));
    return {r, c};
  endfunction

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model of one accepted pixel: skip border pixels where configured and
  // stop each count at the counter maximum.
  task automatic modelWrite(logic [13:0] addr, logic [7:0] data);
    int  row;
    int  col;
    bit  border;
    row    = int'(addr[13:7]);
    col    = int'(addr[6:0]);
    border = (row == 0) || (row == 127) || (col == 0) || (col == 127);
    for (int k = 0; k < NDUT; k++) begin
      if (!(skipBord[k] && border) && (refHist[k][data] < cntMax[k])) begin
        refHist[k][data]++;
      end
    end
  endtask

  // Drives one pixel write for a single cycle and records it in the model.
  task automatic applyStimulus(logic [13:0] addr, logic [7:0] data, logic fin);
    lbpValid = 1'b1;
    lbpAddr  = addr;
    lbpData  = data;
    finish   = fin;
    modelWrite(addr, data);
    @(negedge clk);
    lbpValid = 1'b0;
  endtask

  // Every output of every instance must be zero.
  task automatic checkAllIdle(string tag);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("%s.valid[%0d]", tag, k), int'(hv[k]), 0);
      checkOutput($sformatf("%s.bin[%0d]", tag, k), int'(hb[k]), 0);
      checkOutput($sformatf("%s.count[%0d]", tag, k), countOf(k), 0);
      checkOutput($sformatf("%s.done[%0d]", tag, k), int'(hd[k]), 0);
      checkOutput($sformatf("%s.overrun[%0d]", tag, k), int'(ov[k]), 0);
    end
  endtask

  // The four drain cycles after the finish edge. hist_valid must stay low
  // until the edge that ends the window and be high right after it.
  task automatic drainPhase(bit withWrites);
    for (int i = 0; i < 4; i++) begin
      if (withWrites) begin
        applyStimulus(interiorAddr(), 8'($urandom_range(0, 255)), 1'b1);
      end else begin
        @(negedge clk);
      end
      for (int k = 0; k < NDUT; k++) begin
        checkOutput($sformatf("drainValid%0d[%0d]", i, k), int'(hv[k]), (i == 3) ? 1 : 0);
      end
    end
  endtask

  // Reads all 256 bins, checking order, counts and stall stability. An
  // injected write during readout must set overrun without touching counts.
  task automatic readHist(bit randomReady, int injectAt, output int cycles);
    int expBin;
    bit prevStall;
    int prevBin [NDUT];
    int prevCnt [NDUT];
    bit rdy;
    bit injected;
    expBin    = 0;
    prevStall = 1'b0;
    injected  = 1'b0;
    cycles    = 0;
    while ((expBin < 256) && (cycles < 4000)) begin
      for (int k = 0; k < NDUT; k++) begin
        checkOutput($sformatf("readValid[%0d]", k), int'(hv[k]), 1);
        if (hv[k]) begin
          checkOutput($sformatf("readBin[%0d]", k), int'(hb[k]), expBin);
          checkOutput($sformatf("readCount[%0d] bin %0d", k, expBin), countOf(k), refHist[k][expBin]);
          if (prevStall) begin
            checkOutput($sformatf("stallBin[%0d]", k), int'(hb[k]), prevBin[k]);
            checkOutput($sformatf("stallCount[%0d]", k), countOf(k), prevCnt[k]);
          end
        end
        prevBin[k] = int'(hb[k]);
        prevCnt[k] = countOf(k);
      end
      rdy       = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      histReady = rdy;
      if (!injected && (expBin == injectAt)) begin
        injected   = 1'b1;
        lbpValid   = 1'b1;
        lbpAddr    = interiorAddr();
        lbpData    = 8'(expBin + 5);
        expOverrun = 1'b1;
      end
      if (rdy && hv[0]) begin
        for (int k = 0; k < NDUT; k++) begin
          captured[k][expBin] = countOf(k);
          refHist[k][expBin]  = 0;
        end
        expBin++;
      end
      prevStall = !rdy;
      @(negedge clk);
      cycles++;
      lbpValid = 1'b0;
    end
    histReady = 1'b0;
    checkOutput("readTimeout binsTransferred", expBin, 256);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("donePulse[%0d]", k), int'(hd[k]), 1);
      checkOutput($sformatf("validAfterDone[%0d]", k), int'(hv[k]), 0);
    end
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("doneWidth[%0d]", k), int'(hd[k]), 0);
      checkOutput($sformatf("overrun[%0d]", k), int'(ov[k]), int'(expOverrun));
    end
  endtask

  // Drops finish so every instance returns to accumulation.
  task automatic closeFrame();
    finish = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Compares captured readouts against the fixed table for one frame.
  task automatic checkTable(int frame);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].frame == frame) begin
        checkOutput($sformatf("table f%0d dut%0d bin%0d", frame, vecs[i].dut, vecs[i].bin),
                    captured[vecs[i].dut][vecs[i].bin], vecs[i].expCount);
      end
    end
  endtask

  // Sum of captured counts outside the two bins a frame is expected to hit.
  function automatic int otherBins(int k, int binA, int binB);
    int s;
    s = 0;
    for (int b = 0; b < 256; b++) begin
      if ((b != binA) && (b != binB)) s += captured[k][b];
    end
    return s;
  endfunction

  // Main sequence: reset, raster frame, saturation frame, random frame with
  // backpressure and overrun, then a reset in the middle of a readout.
  initial begin
    int cyc;
    vecs[0]  = '{0, 0, 0, 0};
    vecs[1]  = '{0, 0, 255, 15876};
    vecs[2]  = '{0, 1, 0, 508};
    vecs[3]  = '{0, 1, 255, 15876};
    vecs[4]  = '{0, 2, 0, 0};
    vecs[5]  = '{0, 2, 255, 15};
    vecs[6]  = '{0, 1, 128, 0};
    vecs[7]  = '{1, 0, 1, 100};
    vecs[8]  = '{1, 0, 60, 20};
    vecs[9]  = '{1, 1, 1, 100};
    vecs[10] = '{1, 1, 60, 20};
    vecs[11] = '{1, 2, 1, 15};
    vecs[12] = '{1, 2, 60, 15};

    reset      = 1'b0;
    lbpValid   = 1'b0;
    lbpAddr    = '0;
    lbpData    = '0;
    finish     = 1'b0;
    histReady  = 1'b0;
    expOverrun = 1'b0;
    repeat (2) @(negedge clk);
    checkAllIdle("reset");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] full raster frame");
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        logic [7:0] code;
        code = ((r == 0) || (r == 127) || (c == 0) || (c == 127)) ? 8'h00 : 8'hFF;
        applyStimulus({7'(r), 7'(c)}, code, (r == 127) && (c == 127));
      end
    end
    drainPhase(1'b0);
    readHist(1'b0, -1, cyc);
    checkOutput("throughput raster", cyc, 256);
    checkTable(0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("rasterOtherBins[%0d]", k), otherBins(k, 0, 255), 0);
    end
    closeFrame();

    $display("[TB] clear-on-read and saturation frame");
    for (int i = 0; i < 100; i++) applyStimulus(14'h0505, 8'h01, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(14'h0A0A, 8'h3C, i == 19);
    drainPhase(1'b0);
    readHist(1'b0, -1, cyc);
    checkOutput("throughput second", cyc, 256);
    checkTable(1);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("secondOtherBins[%0d]", k), otherBins(k, 1, 60), 0);
    end
    closeFrame();

    $display("[TB] random frame with backpressure and overrun");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 255)), i == 299);
      if ((i != 299) && ($urandom_range(0, 3) == 0)) @(negedge clk);
    end
    drainPhase(1'b1);
    readHist(1'b1, 77, cyc);
    closeFrame();

    $display("[TB] reset during readout");
    for (int i = 0; i < 50; i++) begin
      applyStimulus(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 255)), i == 49);
    end
    drainPhase(1'b1);
    histReady = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1 checkAllIdle("asyncReset");
    finish    = 1'b0;
    histReady = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      for (int b = 0; b < 256; b++) refHist[k][b] = 0;
    end
    expOverrun = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 255)), i == 39);
    end
    drainPhase(1'b1);
    readHist(1'b1, -1, cyc);
    closeFrame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
